// File: rtl/uart_pkg.sv
// Shared UART types: LCR/FCR/LSR register layouts and the receiver state encoding.
package uart_pkg;

  localparam int         OVERSAMPLE_DEF = 16;
  localparam logic [3:0] MID_TICK       = 4'd7;

  typedef struct packed {
    logic       dlab;
    logic       set_break;
    logic       sticky_parity;
    logic       eps;
    logic       pen;
    logic       stb;
    logic [1:0] wls;
  } lcr_t;

  typedef struct packed {
    logic [1:0] rx_trig;
    logic [1:0] rsvd;
    logic       dma_mode;
    logic       tx_rst;
    logic       rx_rst;
    logic       fifo_en;
  } fcr_t;

  typedef struct packed {
    logic rx_fifo_err;
    logic temt;
    logic thre;
    logic bi;
    logic fe;
    logic pe;
    logic oe;
    logic dr;
  } lsr_t;

  // state     | meaning
  // IDLE      | line idle, waiting for a falling edge
  // START     | counting to mid start bit to reject glitches
  // DATA      | sampling wls+5 data bits, LSB first
  // PARITY    | sampling the parity bit
  // STOP      | sampling the stop bit, then push/overrun
  // BRK_WAIT  | break seen, waiting for line to return high
  typedef enum logic [2:0] {
    RX_IDLE     = 3'd0,
    RX_START    = 3'd1,
    RX_DATA     = 3'd2,
    RX_PARITY   = 3'd3,
    RX_STOP     = 3'd4,
    RX_BRK_WAIT = 3'd5
  } rx_state_e;

endpackage

// File: rtl/uart_sync.sv
// N-flop bit synchroniser for an asynchronous input; resets to 1 (idle line level).
module uart_sync #(
  parameter int N = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic [N-1:0] r_sync;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_sync <= '1;
    else      r_sync <= {r_sync[N-2:0], d_i};
  end

  assign q_o = r_sync[N-1];

endmodule

// File: rtl/uart_rx.sv
// 16550-style serial receiver: oversampled start/data/parity/stop detection feeding the RX FIFO.
module uart_rx
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE  = OVERSAMPLE_DEF,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       baud_tick_i,
  input  logic       rx_i,
  input  logic [1:0] wls_i,
  input  logic       pen_i,
  input  logic       eps_i,
  input  logic       sticky_par_i,
  input  logic       rx_rst_i,
  input  logic       rx_fifo_full_i,
  output logic       push_o,
  output logic [7:0] data_o,
  output logic       oe_o,
  output logic       pe_o,
  output logic       fe_o,
  output logic       bi_o
);

  localparam logic [3:0] LAST_TICK = 4'(OVERSAMPLE - 1);

  logic       w_rxs;
  logic       w_bit_end;
  logic       w_last_bit;
  logic       w_par_exp;
  logic       w_brk;

  rx_state_e  r_state;
  logic [3:0] r_tick_cnt;
  logic [2:0] r_bit_idx;
  logic [7:0] r_shift;
  logic [1:0] r_wls;
  logic       r_pen;
  logic       r_eps;
  logic       r_stick;
  logic       r_all_zero;
  logic       r_pe_calc;
  logic       r_push;
  logic [7:0] r_data;
  logic       r_oe;
  logic       r_pe;
  logic       r_fe;
  logic       r_bi;

  uart_sync #(.N(SYNC_STAGES)) u_sync (
    .clk (clk),
    .rst (rst),
    .d_i (rx_i),
    .q_o (w_rxs)
  );

  assign w_bit_end  = baud_tick_i && (r_tick_cnt == LAST_TICK);
  assign w_last_bit = (r_bit_idx == ({1'b0, r_wls} + 3'd4));
  // Unused MSBs of r_shift are zero, so a full-width XOR is the data parity.
  assign w_par_exp  = r_stick ? ~r_eps : (r_eps ? ^r_shift : ~^r_shift);
  assign w_brk      = r_all_zero & ~w_rxs;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= RX_IDLE;
      r_tick_cnt <= '0;
      r_bit_idx  <= '0;
      r_shift    <= '0;
      r_wls      <= '0;
      r_pen      <= 1'b0;
      r_eps      <= 1'b0;
      r_stick    <= 1'b0;
      r_all_zero <= 1'b0;
      r_pe_calc  <= 1'b0;
      r_push     <= 1'b0;
      r_data     <= '0;
      r_oe       <= 1'b0;
      r_pe       <= 1'b0;
      r_fe       <= 1'b0;
      r_bi       <= 1'b0;
    end else begin
      r_push <= 1'b0;
      if (rx_rst_i) begin
        r_state    <= RX_IDLE;
        r_tick_cnt <= '0;
        r_oe       <= 1'b0;
        r_pe       <= 1'b0;
        r_fe       <= 1'b0;
        r_bi       <= 1'b0;
      end else begin
        if (baud_tick_i && r_state inside {RX_DATA, RX_PARITY, RX_STOP})
          r_tick_cnt <= (r_tick_cnt == LAST_TICK) ? '0 : r_tick_cnt + 4'd1;
        case (r_state)
          RX_IDLE: begin
            if (!w_rxs) begin
              r_state    <= RX_START;
              r_tick_cnt <= '0;
            end
          end
          RX_START: begin
            if (baud_tick_i) begin
              if (r_tick_cnt != MID_TICK) begin
                r_tick_cnt <= r_tick_cnt + 4'd1;
              end else if (w_rxs) begin
                r_state <= RX_IDLE;
              end else begin
                // Frame format is frozen here for the whole character.
                r_state    <= RX_DATA;
                r_tick_cnt <= '0;
                r_bit_idx  <= '0;
                r_shift    <= '0;
                r_wls      <= wls_i;
                r_pen      <= pen_i;
                r_eps      <= eps_i;
                r_stick    <= sticky_par_i;
                r_all_zero <= 1'b1;
                r_pe_calc  <= 1'b0;
              end
            end
          end
          RX_DATA: begin
            if (w_bit_end) begin
              r_shift[r_bit_idx] <= w_rxs;
              r_all_zero         <= r_all_zero & ~w_rxs;
              r_bit_idx          <= r_bit_idx + 3'd1;
              if (w_last_bit) r_state <= r_pen ? RX_PARITY : RX_STOP;
            end
          end
          RX_PARITY: begin
            if (w_bit_end) begin
              r_pe_calc  <= (w_rxs != w_par_exp);
              r_all_zero <= r_all_zero & ~w_rxs;
              r_state    <= RX_STOP;
            end
          end
          RX_STOP: begin
            if (w_bit_end) begin
              if (rx_fifo_full_i) begin
                r_oe <= 1'b1;
              end else begin
                r_push <= 1'b1;
                r_data <= r_shift;
                r_pe   <= r_pe_calc;
                r_fe   <= ~w_rxs;
                r_bi   <= w_brk;
                r_oe   <= 1'b0;
              end
              r_state <= w_brk ? RX_BRK_WAIT : RX_IDLE;
            end
          end
          RX_BRK_WAIT: begin
            if (w_rxs) r_state <= RX_IDLE;
          end
          default: r_state <= RX_IDLE;
        endcase
      end
    end
  end

  assign push_o = r_push;
  assign data_o = r_data;
  assign oe_o   = r_oe;
  assign pe_o   = r_pe;
  assign fe_o   = r_fe;
  assign bi_o   = r_bi;

endmodule
